dmem_mmio_responder: RTL and testbench

Synthesizable responder for the CPU data-memory port (`d_mem_addr` / `d_mem_wdata` / `d_mem_wen` / `d_mem_rdata`).
- Services loads and stores into a word-addressed RAM with byte-lane writes.
- Decodes an MMIO window holding a test-status register, a free-running cycle counter and a buffered UART transmitter.
- Sits between `cpu_top` and the board top, replacing the simulation-only memory model so programs can report PASS/FAIL and print text on hardware.

---
 rtl/dmem_mmio_responder.sv | 126 ++++++++++++
 tb/tb_dmem_mmio_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-port RAM plus TOHOST, CYCLE and UART MMIO registers.
// Define DMEM_UART_EN to build the UART TX FIFO and serializer; otherwise uart_tx idles high.
module dmem_mmio_responder #(
    parameter int          RAM_WORDS    = 1024,
    parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic [31:0] d_mem_rdata,
    output logic        uart_tx,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] test_code
);
    localparam int AW = $clog2(RAM_WORDS);
    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycle, status;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          ram_hit, mmio_hit;
    assign idx      = d_mem_addr[AW+1:2];
    assign off      = d_mem_addr[3:2];
    assign ram_hit  = d_mem_addr < MMIO_BASE && {2'b0, d_mem_addr[31:2]} < 32'(RAM_WORDS);
    assign mmio_hit = d_mem_addr[31:4] == MMIO_BASE[31:4];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (ram_hit && d_mem_wen[i]) ram[idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cycle     <= '0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            test_code <= '0;
        end else begin
            cycle <= cycle + 1'b1;
            if (mmio_hit && off == 2'd0 && |d_mem_wen && !test_done) begin
                test_done <= 1'b1;
                test_pass <= d_mem_wdata == 32'd1;
                test_code <= d_mem_wdata[31:1];
            end
        end
`ifdef DMEM_UART_EN
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state, state_nxt;
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [BW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_nxt, full, empty, overflow, push_req, push, pop, tick;
    assign full     = cnt == CW'(FIFO_DEPTH);
    assign empty    = cnt == '0;
    assign push_req = mmio_hit && off == 2'd2 && d_mem_wen[0];
    assign pop      = state == IDLE && !empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign tick     = baud == BW'(CLKS_PER_BIT - 1);
    assign status   = {28'b0, overflow, state != IDLE, empty, full};
    always_ff @(posedge clk) if (push) fifo[wp] <= d_mem_wdata[7:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (push_req && !push) overflow <= 1'b1;
            else if (mmio_hit && off == 2'd3 && d_mem_wen[0] && d_mem_wdata[3]) overflow <= 1'b0;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            uart_tx <= tx_nxt;
        end
    always_comb begin
        state_nxt = state;
        baud_nxt  = (state == IDLE || tick) ? '0 : baud + 1'b1;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        tx_nxt    = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
        case (state)
            IDLE: if (pop) begin
                state_nxt = START;
                shreg_nxt = fifo[rp];
            end
            START: if (tick) state_nxt = DATA;
            DATA: if (tick) begin
                shreg_nxt = shreg >> 1;
                bit_nxt   = bit_idx + 1'b1;
                if (bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign uart_tx = 1'b1;
    assign status  = 32'h0000_0002;
`endif
    assign d_mem_rdata = ram_hit       ? ram[idx] :
                         !mmio_hit     ? 32'h0 :
                         off == 2'd0   ? {test_code, test_done} :
                         off == 2'd1   ? cycle :
                         off == 2'd3   ? status : 32'h0;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed checks of RAM lanes, TOHOST, CYCLE and the UART registers.
// UART frame/overflow scenarios run only when DMEM_UART_EN is defined.
module tb_dmem_mmio_responder;
    localparam logic [31:0] MB = 32'h1000_0000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0]  wen = '0;
    logic        uart_tx, test_done, test_pass;
    logic [30:0] test_code;
    int          vectors = 0, miscompares = 0;

    dmem_mmio_responder #(.RAM_WORDS(1024), .MMIO_BASE(MB), .CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .d_mem_addr(addr), .d_mem_wdata(wdata), .d_mem_wen(wen),
        .d_mem_rdata(rdata), .uart_tx(uart_tx), .test_done(test_done), .test_pass(test_pass),
        .test_code(test_code)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        addr = a; wdata = d; wen = e;
        step();
        wen = 4'h0; wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; wen = 4'h0;
        #1;
        d = rdata;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
        vectors++; if (test_done !== 1'b0) begin miscompares++; $display("FAIL reset_test_done got %b want 0", test_done); end
        vectors++; if (test_pass !== 1'b0) begin miscompares++; $display("FAIL reset_test_pass got %b want 0", test_pass); end
        vectors++; if (test_code !== 31'h0) begin miscompares++; $display("FAIL reset_test_code got %h want 0", test_code); end
        rd(MB + 32'hC, v);
        vectors++; if (v !== 32'h2) begin miscompares++; $display("FAIL reset_status got %h want 00000002", v); end
        rd(MB + 32'h4, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL reset_cycle got %h want 0", v); end
        step();
        step();
        rst_n = 1'b1;
        step(); step(); step();
        rd(MB + 32'h4, v);
        vectors++; if (v !== 32'd3) begin miscompares++; $display("FAIL cycle_after_release got %0d want 3", v); end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(32'h40, 32'h1122_3344, 4'b1111);
        wr(32'h40, 32'h00AA_0000, 4'b0100);
        rd(32'h40, v);
        vectors++; if (v !== 32'h11AA_3344) begin miscompares++; $display("FAIL ram_byte_lane got %h want 11aa3344", v); end
        wr(32'h44, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h44, 32'h0000_1234, 4'b0011);
        rd(32'h44, v);
        vectors++; if (v !== 32'hDEAD_1234) begin miscompares++; $display("FAIL ram_half_lane got %h want dead1234", v); end
        wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
        rd(32'hFFC, v);
        vectors++; if (v !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ram_last_word got %h want cafef00d", v); end
        wr(32'h1000, 32'h1234_5678, 4'b1111);
        rd(32'h1000, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped_past_ram got %h want 0", v); end
        wr(32'h5000, 32'h1234_5678, 4'b1111);
        rd(32'h5000, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL unmapped_5000 got %h want 0", v); end
        rd(32'h40, v);
        vectors++; if (v !== 32'h11AA_3344) begin miscompares++; $display("FAIL ram_retained got %h want 11aa3344", v); end
    endtask

    task automatic test_cycle();
        logic [31:0] a, b;
        rd(MB + 32'h4, a);
        wr(MB + 32'h4, 32'h0, 4'b1111);
        rd(MB + 32'h4, b);
        vectors++; if (b !== a + 32'd1) begin miscompares++; $display("FAIL cycle_write_ignored got %h want %h", b, a + 32'd1); end
        repeat (5) step();
        rd(MB + 32'h4, b);
        vectors++; if (b !== a + 32'd6) begin miscompares++; $display("FAIL cycle_increment got %h want %h", b, a + 32'd6); end
    endtask

    task automatic test_tohost_pass();
        logic [31:0] v;
        addr = MB; wdata = 32'd1; wen = 4'b1111;
        #1;
        vectors++; if (test_done !== 1'b0) begin miscompares++; $display("FAIL tohost_before_edge got %b want 0", test_done); end
        step();
        wen = 4'h0;
        vectors++; if ({test_done, test_pass, test_code} !== {1'b1, 1'b1, 31'h0}) begin miscompares++;
            $display("FAIL tohost_pass got done=%b pass=%b code=%h want 1 1 0", test_done, test_pass, test_code); end
        rd(MB, v);
        vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL tohost_read_pass got %h want 1", v); end
        wr(MB, 32'h7, 4'b1111);
        vectors++; if ({test_done, test_pass, test_code} !== {1'b1, 1'b1, 31'h0}) begin miscompares++;
            $display("FAIL tohost_sticky got done=%b pass=%b code=%h want 1 1 0", test_done, test_pass, test_code); end
        rd(MB, v);
        vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL tohost_read_sticky got %h want 1", v); end
    endtask

    task automatic test_tohost_fail();
        logic [31:0] v;
        vectors++; if (test_done !== 1'b0) begin miscompares++; $display("FAIL tohost_cleared got %b want 0", test_done); end
        wr(MB, 32'h7, 4'b0001);
        vectors++; if ({test_done, test_pass, test_code} !== {1'b1, 1'b0, 31'h3}) begin miscompares++;
            $display("FAIL tohost_fail got done=%b pass=%b code=%h want 1 0 3", test_done, test_pass, test_code); end
        rd(MB, v);
        vectors++; if (v !== 32'h7) begin miscompares++; $display("FAIL tohost_read_fail got %h want 7", v); end
    endtask

`ifdef DMEM_UART_EN
    task automatic test_uart_frame();
        logic [31:0] v;
        logic [7:0]  bv = 8'h55;
        logic        e;
        wr(MB + 32'h8, 32'h0000_0055, 4'b0001);
        for (int k = 1; k <= 45; k++) begin
            step();
            e = (k >= 2 && k <= 5) ? 1'b0 : (k >= 6 && k <= 37) ? bv[(k - 6) / 4] : 1'b1;
            vectors++; if (uart_tx !== e) begin miscompares++; $display("FAIL frame_bit_k%0d got %b want %b", k, uart_tx, e); end
            if (k == 1 || k == 40 || k == 42) begin
                rd(MB + 32'hC, v);
                vectors++; if (v !== (k == 42 ? 32'h2 : 32'h6)) begin miscompares++;
                    $display("FAIL frame_status_k%0d got %h want %h", k, v, (k == 42 ? 32'h2 : 32'h6)); end
            end
        end
        rd(MB + 32'h8, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL uart_data_read got %h want 0", v); end
    endtask

    task automatic drain();
        logic [31:0] v;
        for (int n = 0; n < 2000; n++) begin
            rd(MB + 32'hC, v);
            if (v == 32'h2) break;
            step();
        end
        vectors++; if (v !== 32'h2) begin miscompares++; $display("FAIL drain_timeout status got %h want 2", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        for (int n = 0; n < 9; n++) wr(MB + 32'h8, 32'h30 + n, 4'b0001);
        rd(MB + 32'hC, v);
        vectors++; if (v !== 32'h5) begin miscompares++; $display("FAIL nine_push_status got %h want 5", v); end
        drain();
        for (int n = 0; n < 10; n++) wr(MB + 32'h8, 32'h40 + n, 4'b0001);
        rd(MB + 32'hC, v);
        vectors++; if (v !== 32'hD) begin miscompares++; $display("FAIL ten_push_status got %h want d", v); end
        wr(MB + 32'hC, 32'h8, 4'b0001);
        rd(MB + 32'hC, v);
        vectors++; if (v !== 32'h5) begin miscompares++; $display("FAIL overflow_clear got %h want 5", v); end
    endtask
`else
    task automatic test_uart_off();
        logic [31:0] v;
        int          lows = 0;
        wr(MB + 32'h8, 32'h0000_0041, 4'b1111);
        for (int k = 0; k < 12; k++) begin
            if (uart_tx !== 1'b1) lows++;
            step();
        end
        vectors++; if (lows != 0) begin miscompares++; $display("FAIL uart_off_line got %0d low samples want 0", lows); end
        rd(MB + 32'h8, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL uart_off_data got %h want 0", v); end
        rd(MB + 32'hC, v);
        vectors++; if (v !== 32'h2) begin miscompares++; $display("FAIL uart_off_status got %h want 2", v); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int          lows = 0;
        apply_reset();
        wr(MB + 32'h8, 32'h0000_0000, 4'b0001);
        wr(MB + 32'h8, 32'h0000_0033, 4'b0001);
        repeat (14) step();
`ifdef DMEM_UART_EN
        vectors++; if (uart_tx !== 1'b0) begin miscompares++; $display("FAIL mid_frame_data_low got %b want 0", uart_tx); end
`endif
        rst_n = 1'b0;
        #1;
        vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL mid_reset_uart_tx got %b want 1", uart_tx); end
        rd(MB + 32'hC, v);
        vectors++; if (v !== 32'h2) begin miscompares++; $display("FAIL mid_reset_status got %h want 2", v); end
        step();
        step();
        rst_n = 1'b1;
        rd(MB + 32'h4, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL mid_reset_cycle got %h want 0", v); end
        for (int k = 0; k < 12; k++) begin
            step();
            if (uart_tx !== 1'b1) lows++;
        end
        vectors++; if (lows != 0) begin miscompares++; $display("FAIL fifo_flushed got %0d low samples want 0", lows); end
        rd(MB + 32'h4, v);
        vectors++; if (v !== 32'd12) begin miscompares++; $display("FAIL cycle_after_mid_reset got %0d want 12", v); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_cycle();
        test_tohost_pass();
        apply_reset();
        test_tohost_fail();
`ifdef DMEM_UART_EN
        test_uart_frame();
        test_overflow();
`else
        test_uart_off();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
